// File: rtl/babylonian_pkg.sv
// Shared definitions for the alarm trigger: state encoding and time field limits.
package babylonian_pkg;

  typedef enum logic [1:0] {
    ST_OFF   = 2'd0,
    ST_ARMED = 2'd1,
    ST_RING  = 2'd2,
    ST_SNZ   = 2'd3
  } state_t;

  localparam int MIN_W = 6;
  localparam int HR_W  = 5;

  localparam logic [MIN_W-1:0] MIN_MAX = 6'd59;
  localparam logic [HR_W-1:0]  HR_MAX  = 5'd23;

endpackage

// File: rtl/babylonian_time_match.sv
// Time-of-day versus alarm comparator with range check; emits a one-cycle
// trigger on the rising edge of a valid match.
module babylonian_time_match
  import babylonian_pkg::*;
(
  input  logic             clk,
  input  logic             srst,
  input  logic [MIN_W-1:0] cur_minutes,
  input  logic [HR_W-1:0]  cur_hours,
  input  logic [MIN_W-1:0] alm_minutes,
  input  logic [HR_W-1:0]  alm_hours,
  input  logic             alm_en,
  input  logic             setup,
  output logic             trigger
);

  logic match;
  logic match_q;

  // Out-of-range alarm settings can never match, even if the clock shows the same value.
  always_comb begin
    match = alm_en && !setup &&
            (cur_minutes == alm_minutes) && (cur_hours == alm_hours) &&
            (alm_minutes <= MIN_MAX) && (alm_hours <= HR_MAX);
  end

  // match_q resets high so an equality already present at reset does not fire.
  always_ff @(posedge clk) begin
    if (srst) begin
      match_q <= 1'b1;
    end else begin
      match_q <= match;
    end
  end

  assign trigger = match && !match_q;

endmodule

// File: rtl/babylonian_alarm_trigger.sv
// Alarm ring/snooze/stop sequencer driving the buzzer and status outputs.
module babylonian_alarm_trigger
  import babylonian_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic             C,
  input  logic             CLR,
  input  logic             TICK_SEC,
  input  logic [MIN_W-1:0] CUR_MINUTES,
  input  logic [HR_W-1:0]  CUR_HOURS,
  input  logic [MIN_W-1:0] ALM_MINUTES,
  input  logic [HR_W-1:0]  ALM_HOURS,
  input  logic             ALM_EN,
  input  logic             SETUP,
  input  logic             SNOOZE,
  input  logic             STOP,
  output logic             BUZZ,
  output logic             RINGING,
  output logic             SNOOZING,
  output logic [1:0]       SNOOZE_LEFT
);

  localparam logic [8:0] RING_LAST   = 9'(RING_SEC - 1);
  localparam logic [8:0] SNOOZE_LAST = 9'(SNOOZE_SEC - 1);
  localparam logic [1:0] SNOOZE_INIT = 2'(MAX_SNOOZE);

  logic       trigger;
  state_t     state_reg, state_next;
  logic [8:0] sec_cnt_reg, sec_cnt_next;
  logic       beep_reg, beep_next;
  logic [1:0] snooze_left_reg, snooze_left_next;

  babylonian_time_match u_match (
    .clk         (C),
    .srst        (CLR),
    .cur_minutes (CUR_MINUTES),
    .cur_hours   (CUR_HOURS),
    .alm_minutes (ALM_MINUTES),
    .alm_hours   (ALM_HOURS),
    .alm_en      (ALM_EN),
    .setup       (SETUP),
    .trigger     (trigger)
  );

  // Next-state logic; exits from RING/SNZ take priority over timers and snooze.
  always_comb begin
    state_next       = state_reg;
    sec_cnt_next     = sec_cnt_reg;
    beep_next        = beep_reg;
    snooze_left_next = snooze_left_reg;
    case (state_reg)
      ST_OFF: begin
        if (ALM_EN && !SETUP) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (!ALM_EN) begin
          state_next = ST_OFF;
        end else if (trigger) begin
          state_next       = ST_RING;
          sec_cnt_next     = '0;
          beep_next        = 1'b1;
          snooze_left_next = SNOOZE_INIT;
        end
      end
      ST_RING, ST_SNZ: begin
        if (!ALM_EN || SETUP || STOP) begin
          state_next       = ALM_EN ? ST_ARMED : ST_OFF;
          sec_cnt_next     = '0;
          beep_next        = 1'b0;
          snooze_left_next = SNOOZE_INIT;
        end else if (state_reg == ST_RING) begin
          if (TICK_SEC && sec_cnt_reg == RING_LAST) begin
            // Timed out: back to armed, the still-equal minute cannot re-trigger.
            state_next       = ST_ARMED;
            sec_cnt_next     = '0;
            beep_next        = 1'b0;
            snooze_left_next = SNOOZE_INIT;
          end else if (SNOOZE && snooze_left_reg != 2'd0) begin
            state_next       = ST_SNZ;
            sec_cnt_next     = '0;
            snooze_left_next = snooze_left_reg - 2'd1;
          end else if (TICK_SEC) begin
            sec_cnt_next = sec_cnt_reg + 9'd1;
            beep_next    = !beep_reg;
          end
        end else begin
          if (TICK_SEC && sec_cnt_reg == SNOOZE_LAST) begin
            state_next   = ST_RING;
            sec_cnt_next = '0;
            beep_next    = 1'b1;
          end else if (TICK_SEC) begin
            sec_cnt_next = sec_cnt_reg + 9'd1;
          end
        end
      end
      default: state_next = ST_OFF;
    endcase
  end

  // State and registered outputs, decoded from the next state so they track it exactly.
  always_ff @(posedge C) begin
    if (CLR) begin
      state_reg       <= ST_OFF;
      sec_cnt_reg     <= '0;
      beep_reg        <= 1'b0;
      snooze_left_reg <= SNOOZE_INIT;
      BUZZ            <= 1'b0;
      RINGING         <= 1'b0;
      SNOOZING        <= 1'b0;
      SNOOZE_LEFT     <= SNOOZE_INIT;
    end else begin
      state_reg       <= state_next;
      sec_cnt_reg     <= sec_cnt_next;
      beep_reg        <= beep_next;
      snooze_left_reg <= snooze_left_next;
      BUZZ            <= (state_next == ST_RING) && beep_next;
      RINGING         <= (state_next == ST_RING);
      SNOOZING        <= (state_next == ST_SNZ);
      SNOOZE_LEFT     <= snooze_left_next;
    end
  end

endmodule

// File: tb/tb_babylonian_alarm_trigger.sv
// Directed bench for babylonian_alarm_trigger with default parameters.
module tb_babylonian_alarm_trigger;

  logic       C = 1'b0;
  logic       CLR = 1'b1;
  logic       TICK_SEC = 1'b0;
  logic [5:0] CUR_MINUTES = 6'd0;
  logic [4:0] CUR_HOURS = 5'd0;
  logic [5:0] ALM_MINUTES = 6'd0;
  logic [4:0] ALM_HOURS = 5'd0;
  logic       ALM_EN = 1'b1;
  logic       SETUP = 1'b0;
  logic       SNOOZE = 1'b0;
  logic       STOP = 1'b0;
  logic       BUZZ, RINGING, SNOOZING;
  logic [1:0] SNOOZE_LEFT;

  int total = 0;
  int bad = 0;

  babylonian_alarm_trigger dut (
    .C           (C),
    .CLR         (CLR),
    .TICK_SEC    (TICK_SEC),
    .CUR_MINUTES (CUR_MINUTES),
    .CUR_HOURS   (CUR_HOURS),
    .ALM_MINUTES (ALM_MINUTES),
    .ALM_HOURS   (ALM_HOURS),
    .ALM_EN      (ALM_EN),
    .SETUP       (SETUP),
    .SNOOZE      (SNOOZE),
    .STOP        (STOP),
    .BUZZ        (BUZZ),
    .RINGING     (RINGING),
    .SNOOZING    (SNOOZING),
    .SNOOZE_LEFT (SNOOZE_LEFT)
  );

  always #5 C = ~C;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Advance n clock edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge C);
    #1;
  endtask

  task automatic tick();
    TICK_SEC = 1'b1;
    step(1);
    TICK_SEC = 1'b0;
  endtask

  task automatic status(input string tag, input int ring, input int snz, input int buzz, input int left);
    check({tag, ".ringing"}, int'(RINGING), ring);
    check({tag, ".snoozing"}, int'(SNOOZING), snz);
    check({tag, ".buzz"}, int'(BUZZ), buzz);
    check({tag, ".left"}, int'(SNOOZE_LEFT), left);
  endtask

  task automatic set_cur(input int h, input int m);
    CUR_HOURS = 5'(h);
    CUR_MINUTES = 6'(m);
  endtask

  task automatic set_alm(input int h, input int m);
    ALM_HOURS = 5'(h);
    ALM_MINUTES = 6'(m);
  endtask

  // Force a fresh match edge on ALM=07:30 and confirm ringing starts.
  task automatic ring_0730(input string tag);
    set_cur(7, 31);
    step(2);
    set_cur(7, 30);
    step(1);
    status(tag, 1, 0, 1, 3);
  endtask

  initial begin
    // Reset with CUR==ALM=00:00 already equal.
    step(2);
    status("reset", 0, 0, 0, 3);
    CLR = 1'b0;
    step(3);
    status("eq_at_reset", 0, 0, 0, 3);
    $display("transaction: reset release with equal time, no ring");

    // ALM_EN dropped and raised while equal.
    ALM_EN = 1'b0;
    step(1);
    ALM_EN = 1'b1;
    step(4);
    check("en_raise.ringing", int'(RINGING), 0);
    $display("transaction: ALM_EN toggle while equal, no ring");

    // Midnight rollover.
    set_cur(23, 59);
    step(2);
    check("pre_midnight.ringing", int'(RINGING), 0);
    set_cur(0, 0);
    step(1);
    status("midnight", 1, 0, 1, 3);
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
    status("midnight_stop", 0, 0, 0, 3);
    step(3);
    check("midnight_noretrig", int'(RINGING), 0);
    $display("transaction: 23:59->00:00 rings, STOP returns to armed");

    // Ring timeout with beep toggling on every tick.
    set_alm(7, 30);
    set_cur(7, 29);
    step(2);
    check("0729.ringing", int'(RINGING), 0);
    set_cur(7, 30);
    step(1);
    status("ring_start", 1, 0, 1, 3);
    for (int k = 1; k <= 59; k++) begin
      tick();
      check($sformatf("beep_t%0d", k), int'(BUZZ), (k % 2 == 0) ? 1 : 0);
    end
    check("t59.ringing", int'(RINGING), 1);
    tick();
    status("timeout", 0, 0, 0, 3);
    tick();
    step(3);
    check("timeout_noretrig", int'(RINGING), 0);
    $display("transaction: 60-tick ring timeout, no re-trigger");

    // Snooze three times, then snooze exhausted.
    ring_0730("snz_ring");
    for (int s = 1; s <= 3; s++) begin
      SNOOZE = 1'b1;
      step(1);
      SNOOZE = 1'b0;
      status($sformatf("snz%0d_enter", s), 0, 1, 0, 3 - s);
      repeat (100) tick();
      SNOOZE = 1'b1;
      step(1);
      SNOOZE = 1'b0;
      check($sformatf("snz%0d_ignored", s), int'(SNOOZE_LEFT), 3 - s);
      repeat (199) tick();
      check($sformatf("snz%0d_t299", s), int'(SNOOZING), 1);
      tick();
      status($sformatf("snz%0d_wake", s), 1, 0, 1, 3 - s);
      $display("transaction: snooze %0d completed 300 ticks", s);
    end
    SNOOZE = 1'b1;
    step(1);
    SNOOZE = 1'b0;
    status("snz_exhausted", 1, 0, 1, 0);
    STOP = 1'b1;
    step(1);
    STOP = 1'b0;
    status("snz_stop", 0, 0, 0, 3);
    $display("transaction: snooze limit reached, STOP restores count");

    // SNOOZE and STOP together: STOP wins.
    ring_0730("both_ring");
    SNOOZE = 1'b1;
    STOP = 1'b1;
    step(1);
    SNOOZE = 1'b0;
    STOP = 1'b0;
    status("both", 0, 0, 0, 3);
    step(2);
    check("both_after.snoozing", int'(SNOOZING), 0);
    $display("transaction: SNOOZE+STOP same cycle goes to armed");

    // Timeout coinciding with STOP.
    ring_0730("tstop_ring");
    repeat (59) tick();
    TICK_SEC = 1'b1;
    STOP = 1'b1;
    step(1);
    TICK_SEC = 1'b0;
    STOP = 1'b0;
    status("timeout_stop", 0, 0, 0, 3);
    $display("transaction: timeout and STOP together");

    // Out-of-range alarm values never ring.
    set_alm(7, 60);
    set_cur(7, 59);
    step(2);
    set_cur(7, 60);
    step(2);
    check("alm_min60", int'(RINGING), 0);
    set_alm(7, 63);
    set_cur(7, 59);
    step(2);
    set_cur(7, 63);
    step(2);
    check("alm_min63", int'(RINGING), 0);
    set_alm(24, 0);
    set_cur(23, 0);
    step(2);
    set_cur(24, 0);
    step(2);
    check("alm_hr24", int'(RINGING), 0);
    set_alm(31, 0);
    set_cur(30, 0);
    step(2);
    set_cur(31, 0);
    step(2);
    check("alm_hr31", int'(RINGING), 0);
    $display("transaction: out-of-range alarm values never ring");

    // SETUP during ring.
    set_alm(7, 30);
    ring_0730("setup_ring");
    SETUP = 1'b1;
    step(1);
    status("setup", 0, 0, 0, 3);
    set_cur(7, 31);
    step(1);
    SETUP = 1'b0;
    step(2);
    check("setup_after", int'(RINGING), 0);
    $display("transaction: SETUP during ring returns to armed");

    // ALM_EN dropped during ring.
    ring_0730("en_ring");
    ALM_EN = 1'b0;
    step(1);
    status("en_off", 0, 0, 0, 3);
    ALM_EN = 1'b1;
    step(2);
    $display("transaction: ALM_EN low during ring goes off");

    // Reset mid-snooze, then armed again after release.
    ring_0730("clr_ring");
    SNOOZE = 1'b1;
    step(1);
    SNOOZE = 1'b0;
    repeat (150) tick();
    status("clr_pre", 0, 1, 0, 2);
    CLR = 1'b1;
    step(1);
    status("clr_mid_snz", 0, 0, 0, 3);
    CLR = 1'b0;
    step(2);
    set_cur(7, 31);
    step(2);
    set_cur(7, 30);
    step(1);
    status("clr_rearmed", 1, 0, 1, 3);
    $display("transaction: CLR mid-snooze, armed again after release");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
